// File: rtl/base_aburp_arb.sv
// base_aburp_arb: N-way round-robin arbiter merging valid/ready streams onto
// one output. Every input owns a one-entry burp (skid) register so its ready
// is a flop output, and multi-beat transfers (closed by an end beat) are never
// interleaved with traffic from other inputs.
module base_aburp_arb #(
   parameter int ways  = 4,
   parameter int width = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ways-1:0]       i_v,
   output logic [ways-1:0]       i_r,
   input  logic [ways*width-1:0] i_d,
   input  logic [ways-1:0]       i_e,
   output logic                  o_v,
   input  logic                  o_r,
   output logic [width-1:0]      o_d,
   output logic                  o_e,
   output logic [ways-1:0]       o_s
);

   localparam int PW = (ways > 1) ? $clog2(ways) : 1;
   localparam logic [PW-1:0] LAST = PW'(ways - 1);

   // burp registers: valid is control, payload is data
   logic [ways-1:0]  r_burp_v;
   logic [width-1:0] r_burp_d [ways];
   logic [ways-1:0]  r_burp_e;

   // arbitration state
   logic             r_lock;
   logic             r_hold;
   logic [PW-1:0]    r_lock_src;
   logic [PW-1:0]    r_prev;
   logic [PW-1:0]    r_ptr;

   // effective request per input: parked beat wins over the live one
   logic [ways-1:0]  w_eff_v;
   logic [ways-1:0]  w_eff_e;
   logic [width-1:0] w_eff_d [ways];
   logic [ways-1:0]  w_take;

   logic [PW-1:0]    w_search;
   logic [PW-1:0]    w_grant;
   logic [PW-1:0]    w_idx;
   logic [PW:0]      w_sum;
   logic             w_found;

   assign i_r = ~r_burp_v;

   for (genvar k = 0; k < ways; k++) begin : g_in
      assign w_eff_v[k] = r_burp_v[k] | i_v[k];
      assign w_eff_d[k] = r_burp_v[k] ? r_burp_d[k] : i_d[k*width +: width];
      assign w_eff_e[k] = r_burp_v[k] ? r_burp_e[k] : i_e[k];
      assign o_s[k]     = o_v & (w_grant == PW'(k));
      assign w_take[k]  = o_v & o_r & o_s[k];
   end

   // round-robin search: first requesting input at or after ptr, wrapping
   always_comb begin
      w_search = r_ptr;
      w_found  = 1'b0;
      w_sum    = '0;
      w_idx    = '0;
      for (int i = 0; i < ways; i++) begin
         w_sum = {1'b0, r_ptr} + (PW+1)'(i);
         if (w_sum >= (PW+1)'(ways)) w_sum = w_sum - (PW+1)'(ways);
         w_idx = w_sum[PW-1:0];
         if (!w_found && w_eff_v[w_idx]) begin
            w_found  = 1'b1;
            w_search = w_idx;
         end
      end
   end

   // a locked transfer outranks a stalled beat, which outranks a fresh search
   assign w_grant = r_lock ? r_lock_src : (r_hold ? r_prev : w_search);
   assign o_v     = w_eff_v[w_grant];
   assign o_d     = w_eff_d[w_grant];
   assign o_e     = w_eff_e[w_grant];

   // burp occupancy: park a beat that arrives but is not forwarded, free on take
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_burp_v <= '0;
      end else begin
         for (int k = 0; k < ways; k++) begin
            if (!r_burp_v[k] && i_v[k] && !w_take[k]) r_burp_v[k] <= 1'b1;
            else if (r_burp_v[k] && w_take[k])        r_burp_v[k] <= 1'b0;
         end
      end
   end

   // burp payload tracks the live input while the register is empty
   always_ff @(posedge clk) begin
      for (int k = 0; k < ways; k++) begin
         if (!r_burp_v[k]) begin
            r_burp_d[k] <= i_d[k*width +: width];
            r_burp_e[k] <= i_e[k];
         end
      end
   end

   // lock/pointer/hold bookkeeping: ptr only advances past a finished transfer
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_lock     <= 1'b0;
         r_hold     <= 1'b0;
         r_lock_src <= '0;
         r_prev     <= '0;
         r_ptr      <= '0;
      end else begin
         r_hold <= o_v & ~o_r;
         r_prev <= w_grant;
         if (o_v && o_r) begin
            if (!o_e) begin
               r_lock     <= 1'b1;
               r_lock_src <= w_grant;
            end else begin
               r_lock <= 1'b0;
               r_ptr  <= (w_grant == LAST) ? '0 : w_grant + PW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_base_aburp_arb.sv
// Testbench for base_aburp_arb (ways=4, width=64): directed scenarios followed
// by a randomized run compared against a queue-based reference model.
module tb_base_aburp_arb;

   localparam int N  = 4;
   localparam int DW = 64;

   logic            clk;
   logic            reset;
   logic [N-1:0]    i_v;
   logic [N-1:0]    i_r;
   logic [N*DW-1:0] i_d;
   logic [N-1:0]    i_e;
   logic            o_v;
   logic            o_r;
   logic [DW-1:0]   o_d;
   logic            o_e;
   logic [N-1:0]    o_s;

   int n_cmp = 0;
   int n_err = 0;

   // reference model state
   logic [DW:0]   pq [N][$];
   logic [N-1:0]  cur_v;
   logic [DW-1:0] cur_d [N];
   logic [N-1:0]  cur_e;
   logic [N-1:0]  acc;
   logic          mlock;
   logic          mhold;
   int            mlsrc;
   int            mprev;
   int            mptr;
   logic [N-1:0]  meff_v;
   logic [N-1:0]  meff_e;
   logic [DW-1:0] meff_d [N];
   logic [DW:0]   tmp;
   int            g;
   logic          exp_ov;
   logic          exp_oe;
   logic [N-1:0]  exp_os;
   logic [N-1:0]  exp_ir;
   logic          take;
   int            rr_g [5] = '{1, 2, 3, 0, 1};
   int            dr_g [3] = '{2, 3, 0};

   base_aburp_arb #(.ways(N), .width(DW)) dut (
      .clk   (clk),
      .reset (reset),
      .i_v   (i_v),
      .i_r   (i_r),
      .i_d   (i_d),
      .i_e   (i_e),
      .o_v   (o_v),
      .o_r   (o_r),
      .o_d   (o_d),
      .o_e   (o_e),
      .o_s   (o_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_d(input int k, input logic [DW-1:0] d, input logic e);
      i_d[k*DW +: DW] = d;
      i_e[k]          = e;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b1;
      i_v   = '0;
      i_d   = '0;
      i_e   = '0;
      o_r   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      // reset state
      smp();
      chk("rst_ir", 64'(i_r), 64'hF);
      chk("rst_ov", 64'(o_v), 64'h0);
      chk("rst_os", 64'(o_s), 64'h0);

      // single beat on input 2, forwarded the same cycle
      tick();
      i_v = 4'b0100; set_d(2, 64'hA5, 1'b1); o_r = 1'b1;
      smp();
      chk("single_ov", 64'(o_v), 64'h1);
      chk("single_od", o_d, 64'hA5);
      chk("single_oe", 64'(o_e), 64'h1);
      chk("single_os", 64'(o_s), 64'b0100);
      tick();
      i_v = '0;
      smp();
      chk("single_ir", 64'(i_r), 64'hF);
      chk("single_idle", 64'(o_v), 64'h0);

      // backpressure on input 0 (ptr is 3, only input 0 requests)
      tick();
      o_r = 1'b0; i_v = 4'b0001; set_d(0, 64'h11, 1'b1);
      smp();
      chk("bp_os0", 64'(o_s), 64'b0001);
      chk("bp_od0", o_d, 64'h11);
      chk("bp_ir0", 64'(i_r), 64'hF);
      tick();
      set_d(0, 64'h22, 1'b1);
      smp();
      chk("bp_ir1", 64'(i_r), 64'b1110);
      chk("bp_od1", o_d, 64'h11);
      tick();
      smp();
      chk("bp_od2", o_d, 64'h11);
      chk("bp_os2", 64'(o_s), 64'b0001);
      tick();
      o_r = 1'b1;
      smp();
      chk("bp_od3", o_d, 64'h11);
      tick();
      smp();
      chk("bp_od4", o_d, 64'h22);
      chk("bp_ir4", 64'(i_r), 64'hF);
      tick();
      i_v = '0;
      smp();
      chk("bp_idle", 64'(o_v), 64'h0);

      // round robin with every input continuously valid (ptr starts at 1)
      tick();
      i_v = 4'hF; o_r = 1'b1;
      for (int k = 0; k < N; k++) set_d(k, 64'h40 + 64'(k), 1'b1);
      for (int c = 0; c < 5; c++) begin
         smp();
         chk("rr_os", 64'(o_s), 64'(4'b0001 << rr_g[c]));
         chk("rr_od", o_d, 64'h40 + 64'(rr_g[c]));
         tick();
      end
      i_v = '0;
      for (int c = 0; c < 3; c++) begin
         smp();
         chk("drain_os", 64'(o_s), 64'(4'b0001 << dr_g[c]));
         chk("drain_od", o_d, 64'h40 + 64'(dr_g[c]));
         tick();
      end
      smp();
      chk("drain_ov", 64'(o_v), 64'h0);
      chk("drain_ir", 64'(i_r), 64'hF);

      // locked 3-beat transfer on input 1 while input 0 waits (ptr is 1)
      tick();
      i_v = 4'b0011; set_d(1, 64'hB1, 1'b0); set_d(0, 64'h0A, 1'b1);
      smp();
      chk("lock_os1", 64'(o_s), 64'b0010);
      chk("lock_od1", o_d, 64'hB1);
      chk("lock_oe1", 64'(o_e), 64'h0);
      tick();
      set_d(1, 64'hB2, 1'b0);
      smp();
      chk("lock_os2", 64'(o_s), 64'b0010);
      chk("lock_od2", o_d, 64'hB2);
      chk("lock_ir2", 64'(i_r), 64'b1110);
      tick();
      set_d(1, 64'hB3, 1'b1);
      smp();
      chk("lock_os3", 64'(o_s), 64'b0010);
      chk("lock_od3", o_d, 64'hB3);
      chk("lock_oe3", 64'(o_e), 64'h1);
      tick();
      i_v = 4'b0001;
      smp();
      chk("lock_after_os", 64'(o_s), 64'b0001);
      chk("lock_after_od", o_d, 64'h0A);
      chk("lock_after_ir", 64'(i_r), 64'b1110);
      tick();
      i_v = '0;
      smp();
      chk("lock_idle", 64'(o_v), 64'h0);
      chk("lock_idle_ir", 64'(i_r), 64'hF);

      // hold stability: input 3 stalled, inputs 0 and 1 arrive meanwhile
      tick();
      o_r = 1'b0; i_v = 4'b1000; set_d(3, 64'h33, 1'b1);
      smp();
      chk("hold_os0", 64'(o_s), 64'b1000);
      tick();
      i_v = 4'b1011; set_d(0, 64'h0B, 1'b0); set_d(1, 64'h1B, 1'b1);
      smp();
      chk("hold_os1", 64'(o_s), 64'b1000);
      chk("hold_od1", o_d, 64'h33);
      tick();
      i_v = '0;
      smp();
      chk("hold_os2", 64'(o_s), 64'b1000);
      chk("hold_ir2", 64'(i_r), 64'b0100);
      tick();
      o_r = 1'b1;
      smp();
      chk("hold_os3", 64'(o_s), 64'b1000);
      chk("hold_od3", o_d, 64'h33);
      tick();
      smp();
      chk("hold_next_os", 64'(o_s), 64'b0001);
      chk("hold_next_od", o_d, 64'h0B);
      chk("hold_next_oe", 64'(o_e), 64'h0);

      // async reset while locked on input 0 with burps full
      tick();
      o_r = 1'b0; i_v = 4'b0100; set_d(2, 64'h2C, 1'b1);
      smp();
      chk("mid_ov", 64'(o_v), 64'h0);
      chk("mid_ir", 64'(i_r), 64'b1101);
      tick();
      i_v = 4'b0001; set_d(0, 64'h0D, 1'b0);
      smp();
      chk("mid_os", 64'(o_s), 64'b0001);
      chk("mid_ir2", 64'(i_r), 64'b1001);
      #1;
      reset = 1'b1; i_v = '0;
      #1;
      chk("arst_ov", 64'(o_v), 64'h0);
      chk("arst_ir", 64'(i_r), 64'hF);
      chk("arst_os", 64'(o_s), 64'h0);
      @(posedge clk);
      #1;
      reset = 1'b0; o_r = 1'b1; i_v = 4'hF;
      for (int k = 0; k < N; k++) set_d(k, 64'h50 + 64'(k), 1'b1);
      smp();
      chk("arst_first_os", 64'(o_s), 64'b0001);
      chk("arst_first_od", o_d, 64'h50);

      // randomized run against the reference model
      tick();
      reset = 1'b1; i_v = '0; o_r = 1'b0;
      tick();
      reset = 1'b0;
      for (int k = 0; k < N; k++) pq[k].delete();
      cur_v = '0; cur_e = '0; acc = '0;
      for (int k = 0; k < N; k++) cur_d[k] = '0;
      mlock = 1'b0; mhold = 1'b0; mlsrc = 0; mprev = 0; mptr = 0;

      for (int cyc = 0; cyc < 600; cyc++) begin
         for (int k = 0; k < N; k++) begin
            if (!cur_v[k] || acc[k]) begin
               cur_v[k] = ($urandom_range(0, 9) < 6);
               cur_d[k] = {$urandom, $urandom};
               cur_e[k] = ($urandom_range(0, 2) != 0);
            end
            i_d[k*DW +: DW] = cur_d[k];
         end
         i_v = cur_v;
         i_e = cur_e;
         o_r = ($urandom_range(0, 9) < 7);

         smp();
         for (int k = 0; k < N; k++) begin
            if (pq[k].size() != 0) begin
               tmp       = pq[k][0];
               meff_v[k] = 1'b1;
               meff_d[k] = tmp[DW-1:0];
               meff_e[k] = tmp[DW];
            end else begin
               meff_v[k] = cur_v[k];
               meff_d[k] = cur_d[k];
               meff_e[k] = cur_e[k];
            end
            exp_ir[k] = (pq[k].size() == 0);
         end
         if (mlock) g = mlsrc;
         else if (mhold) g = mprev;
         else begin
            g = mptr;
            for (int j = N - 1; j >= 0; j--)
               if (meff_v[(mptr + j) % N]) g = (mptr + j) % N;
         end
         exp_ov = meff_v[g];
         exp_oe = meff_e[g];
         exp_os = exp_ov ? 4'(4'b0001 << g) : 4'b0000;
         chk("rnd_ov", 64'(o_v), 64'(exp_ov));
         chk("rnd_os", 64'(o_s), 64'(exp_os));
         chk("rnd_ir", 64'(i_r), 64'(exp_ir));
         if (exp_ov) begin
            chk("rnd_od", o_d, meff_d[g]);
            chk("rnd_oe", 64'(o_e), 64'(exp_oe));
         end

         @(posedge clk);
         take = exp_ov && o_r;
         for (int k = 0; k < N; k++) begin
            acc[k] = cur_v[k] && (pq[k].size() == 0);
            if (pq[k].size() != 0) begin
               if (take && g == k) tmp = pq[k].pop_front();
            end else if (cur_v[k] && !(take && g == k)) begin
               pq[k].push_back({cur_e[k], cur_d[k]});
            end
         end
         if (take) begin
            if (!exp_oe) begin
               mlock = 1'b1;
               mlsrc = g;
            end else begin
               mlock = 1'b0;
               mptr  = (g + 1) % N;
            end
         end
         mhold = exp_ov && !o_r;
         mprev = g;
         #1;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
